// File: rtl/ctrl_types.sv
// rtl/ctrl_types.sv - shared types for the pipeline stall/flush/forward controller
package ctrl_types;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        D_DONE = 2'd2,
        I_DONE = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_WB    = 2'd2
    } fwd_sel_t;

    // The youngest producer wins, so EX/MEM beats MEM/WB when both match.
    function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit) begin
            return FWD_EXMEM;
        end
        if (memwb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational operand forwarding select and RAW hazard compare
module fwd_unit
    import ctrl_types::*;
#(
    parameter int REG_W      = 5,
    parameter bit ENABLE_FWD = 1'b1
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] idex_rs1,
    input  logic [REG_W-1:0] idex_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             idex_wr,
    input  logic             exmem_wr,
    input  logic             memwb_wr,
    input  logic             idex_is_load,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b,
    output logic             hazard
);

    logic exmem_live;
    logic memwb_live;
    logic idex_live;
    logic rs1_live;
    logic rs2_live;
    logic a_exmem;
    logic a_memwb;
    logic b_exmem;
    logic b_memwb;
    logic load_use;
    logic raw_any;

    assign exmem_live = exmem_wr && (exmem_rd != '0);
    assign memwb_live = memwb_wr && (memwb_rd != '0);
    assign idex_live  = idex_wr && (idex_rd != '0);

    assign a_exmem = exmem_live && (exmem_rd == idex_rs1);
    assign a_memwb = memwb_live && (memwb_rd == idex_rs1);
    assign b_exmem = exmem_live && (exmem_rd == idex_rs2);
    assign b_memwb = memwb_live && (memwb_rd == idex_rs2);

    assign rs1_live = id_use_rs1 && (id_rs1 != '0);
    assign rs2_live = id_use_rs2 && (id_rs2 != '0);

    // Loaded data only exists after MEM, so even with forwarding the consumer must wait one cycle.
    assign load_use = idex_is_load && (idex_rd != '0) &&
                      ((rs1_live && (id_rs1 == idex_rd)) || (rs2_live && (id_rs2 == idex_rd)));

    // Without forwarding a source is unsafe until its producer has retired out of WB.
    assign raw_any = (rs1_live && ((idex_live  && (idex_rd  == id_rs1)) ||
                                   (exmem_live && (exmem_rd == id_rs1)) ||
                                   (memwb_live && (memwb_rd == id_rs1)))) ||
                     (rs2_live && ((idex_live  && (idex_rd  == id_rs2)) ||
                                   (exmem_live && (exmem_rd == id_rs2)) ||
                                   (memwb_live && (memwb_rd == id_rs2))));

    always_comb begin
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        hazard = 1'b0;
        if (ENABLE_FWD) begin
            fwd_a  = fwd_pick(a_exmem, a_memwb);
            fwd_b  = fwd_pick(b_exmem, b_memwb);
            hazard = load_use;
        end else begin
            hazard = raw_any;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall, flush and forwarding controller for the 5-stage RV32I pipeline
module pipeline_ctrl
    import ctrl_types::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_W      = 5,
    parameter bit ENABLE_FWD = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_resp,
    input  logic [XLEN-1:0]  icache_rdata,
    input  logic             dcache_resp,
    input  logic [XLEN-1:0]  dcache_rdata,
    input  logic             mem_op,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] idex_rs1,
    input  logic [REG_W-1:0] idex_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             idex_wr,
    input  logic             exmem_wr,
    input  logic             memwb_wr,
    input  logic             idex_is_load,
    input  logic             redirect,
    output logic             icache_req,
    output logic             dcache_req,
    output logic [XLEN-1:0]  if_rdata,
    output logic [XLEN-1:0]  mem_rdata,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             idex_load,
    output logic             exmem_load,
    output logic             memwb_load,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    mem_state_t      state;
    mem_state_t      state_nx;
    logic [XLEN-1:0] i_hold;
    logic [XLEN-1:0] d_hold;
    logic            i_latch;
    logic            d_latch;
    logic            d_ok;
    logic            mem_stall;
    logic            hazard;
    logic            count_stall;
    logic            count_flush;
    fwd_sel_t        fwd_a_sel;
    fwd_sel_t        fwd_b_sel;

    fwd_unit #(
        .REG_W      (REG_W),
        .ENABLE_FWD (ENABLE_FWD)
    ) u_fwd (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .idex_rs1     (idex_rs1),
        .idex_rs2     (idex_rs2),
        .idex_rd      (idex_rd),
        .exmem_rd     (exmem_rd),
        .memwb_rd     (memwb_rd),
        .idex_wr      (idex_wr),
        .exmem_wr     (exmem_wr),
        .memwb_wr     (memwb_wr),
        .idex_is_load (idex_is_load),
        .fwd_a        (fwd_a_sel),
        .fwd_b        (fwd_b_sel),
        .hazard       (hazard)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            i_hold       <= '0;
            d_hold       <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_nx;
            if (i_latch) begin
                i_hold <= icache_rdata;
            end
            if (d_latch) begin
                d_hold <= dcache_rdata;
            end
            if (count_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (count_flush) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // The pipeline is frozen while not in RUN, so mem_op is stable and tells whether a dcache access is owed.
    assign d_ok = !mem_op || dcache_resp;

    always_comb begin
        state_nx = state;
        i_latch  = 1'b0;
        d_latch  = 1'b0;
        case (state)
            RUN, WAIT: begin
                if (icache_resp && d_ok) begin
                    state_nx = RUN;
                end else if (icache_resp) begin
                    state_nx = I_DONE;
                    i_latch  = 1'b1;
                end else if (mem_op && dcache_resp) begin
                    state_nx = D_DONE;
                    d_latch  = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            D_DONE: begin
                if (icache_resp) begin
                    state_nx = RUN;
                end
            end
            I_DONE: begin
                if (dcache_resp) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    assign mem_stall = (state_nx != RUN);

    always_comb begin
        icache_req  = (state != I_DONE);
        dcache_req  = mem_op && (state != D_DONE);
        pc_load     = 1'b1;
        ifid_load   = 1'b1;
        idex_load   = 1'b1;
        exmem_load  = 1'b1;
        memwb_load  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        fwd_a       = fwd_a_sel;
        fwd_b       = fwd_b_sel;
        count_stall = 1'b0;
        count_flush = 1'b0;
        if (!rst) begin
            icache_req = 1'b1;
            dcache_req = 1'b0;
            fwd_a      = FWD_RF;
            fwd_b      = FWD_RF;
        end else if (mem_stall) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            idex_load   = 1'b0;
            exmem_load  = 1'b0;
            memwb_load  = 1'b0;
            count_stall = 1'b1;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            count_flush = 1'b1;
        end else if (hazard) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            idex_flush  = 1'b1;
            count_stall = 1'b1;
        end
    end

    assign if_rdata  = (rst && (state == I_DONE)) ? i_hold : icache_rdata;
    assign mem_rdata = (rst && (state == D_DONE)) ? d_hold : dcache_rdata;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl in both forwarding modes
module tb_pipeline_ctrl;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 32;
    localparam int CYCLES = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic             icache_resp;
    logic [XLEN-1:0]  icache_rdata;
    logic             dcache_resp;
    logic [XLEN-1:0]  dcache_rdata;
    logic             mem_op;
    logic [REG_W-1:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic             id_use_rs1, id_use_rs2, idex_wr, exmem_wr, memwb_wr, idex_is_load, redirect;

    logic             f_icache_req, f_dcache_req, f_pc_load, f_ifid_load, f_idex_load, f_exmem_load, f_memwb_load;
    logic             f_ifid_flush, f_idex_flush, f_exmem_flush;
    logic [1:0]       f_fwd_a, f_fwd_b;
    logic [XLEN-1:0]  f_if_rdata, f_mem_rdata;
    logic [CNT_W-1:0] f_stall_cycles, f_flush_count;

    logic             n_icache_req, n_dcache_req, n_pc_load, n_ifid_load, n_idex_load, n_exmem_load, n_memwb_load;
    logic             n_ifid_flush, n_idex_flush, n_exmem_flush;
    logic [1:0]       n_fwd_a, n_fwd_b;
    logic [XLEN-1:0]  n_if_rdata, n_mem_rdata;
    logic [CNT_W-1:0] n_stall_cycles, n_flush_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.XLEN(XLEN), .REG_W(REG_W), .ENABLE_FWD(1'b1), .CNT_W(CNT_W)) dut_fwd (
        .clk(clk), .rst(rst), .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata), .mem_op(mem_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .exmem_rd(exmem_rd),
        .memwb_rd(memwb_rd), .idex_wr(idex_wr), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
        .idex_is_load(idex_is_load), .redirect(redirect),
        .icache_req(f_icache_req), .dcache_req(f_dcache_req), .if_rdata(f_if_rdata), .mem_rdata(f_mem_rdata),
        .pc_load(f_pc_load), .ifid_load(f_ifid_load), .idex_load(f_idex_load), .exmem_load(f_exmem_load),
        .memwb_load(f_memwb_load), .ifid_flush(f_ifid_flush), .idex_flush(f_idex_flush),
        .exmem_flush(f_exmem_flush), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b),
        .stall_cycles(f_stall_cycles), .flush_count(f_flush_count)
    );

    pipeline_ctrl #(.XLEN(XLEN), .REG_W(REG_W), .ENABLE_FWD(1'b0), .CNT_W(CNT_W)) dut_nofwd (
        .clk(clk), .rst(rst), .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata), .mem_op(mem_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .exmem_rd(exmem_rd),
        .memwb_rd(memwb_rd), .idex_wr(idex_wr), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
        .idex_is_load(idex_is_load), .redirect(redirect),
        .icache_req(n_icache_req), .dcache_req(n_dcache_req), .if_rdata(n_if_rdata), .mem_rdata(n_mem_rdata),
        .pc_load(n_pc_load), .ifid_load(n_ifid_load), .idex_load(n_idex_load), .exmem_load(n_exmem_load),
        .memwb_load(n_memwb_load), .ifid_flush(n_ifid_flush), .idex_flush(n_idex_flush),
        .exmem_flush(n_exmem_flush), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
        .stall_cycles(n_stall_cycles), .flush_count(n_flush_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction-level view of which cache responses are already in hand.
    bit               m_i_have, m_d_have;
    logic [XLEN-1:0]  m_i_data, m_d_data;
    logic [CNT_W-1:0] m_stall [2];
    logic [CNT_W-1:0] m_flush [2];

    function automatic bit hazard_of(input int mode);
        logic [REG_W-1:0] prod_rd [3];
        bit               prod_wr [3];
        bit               h = 1'b0;
        prod_rd = '{idex_rd, exmem_rd, memwb_rd};
        prod_wr = '{idex_wr, exmem_wr, memwb_wr};
        for (int s = 0; s < 2; s++) begin
            logic [REG_W-1:0] src = (s == 0) ? id_rs1 : id_rs2;
            bit               use_it = (s == 0) ? id_use_rs1 : id_use_rs2;
            if (use_it && src != 0) begin
                if (mode == 1) begin
                    h |= idex_is_load && (src == idex_rd);
                end else begin
                    for (int p = 0; p < 3; p++) h |= prod_wr[p] && (prod_rd[p] == src);
                end
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] fwd_of(input int mode, input logic [REG_W-1:0] rs);
        if (mode == 0 || rs == 0) return 2'd0;
        if (exmem_wr && exmem_rd == rs) return 2'd1;
        if (memwb_wr && memwb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    initial begin
        bit               prev_stall = 1'b0;
        bit               have_i, have_d, released, hz;
        bit               st_inc [2];
        bit               fl_inc [2];
        logic [13:0]      exp_ctrl [2];
        logic [13:0]      got_ctrl [2];
        logic [XLEN-1:0]  exp_if, exp_mem;
        bit [6:0]         loads;
        bit [2:0]         flushes;

        {rst, icache_resp, dcache_resp, mem_op, redirect} = '0;
        {icache_rdata, dcache_rdata} = '0;
        {id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
        {id_use_rs1, id_use_rs2, idex_wr, exmem_wr, memwb_wr, idex_is_load} = '0;
        m_i_have = 0; m_d_have = 0; m_i_data = '0; m_d_data = '0;
        m_stall = '{default: '0};
        m_flush = '{default: '0};

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            rst = !(cyc < 2 || $urandom_range(0, 99) == 0);
            if (!prev_stall) mem_op = ($urandom_range(0, 2) == 0);
            icache_resp  = ($urandom_range(0, 2) != 0);
            dcache_resp  = ($urandom_range(0, 1) != 0);
            icache_rdata = $urandom;
            dcache_rdata = $urandom;
            redirect     = ($urandom_range(0, 7) == 0);
            id_rs1   = REG_W'($urandom_range(0, 3));
            id_rs2   = REG_W'($urandom_range(0, 3));
            idex_rs1 = REG_W'($urandom_range(0, 3));
            idex_rs2 = REG_W'($urandom_range(0, 3));
            idex_rd  = REG_W'($urandom_range(0, 3));
            exmem_rd = REG_W'($urandom_range(0, 3));
            memwb_rd = REG_W'($urandom_range(0, 3));
            {id_use_rs1, id_use_rs2, idex_wr, exmem_wr, memwb_wr} = 5'($urandom);
            idex_is_load = ($urandom_range(0, 3) == 0);
            #1;

            have_i   = m_i_have || icache_resp;
            have_d   = !mem_op || m_d_have || dcache_resp;
            released = have_i && have_d;

            for (int mode = 0; mode < 2; mode++) begin
                hz = hazard_of(mode);
                st_inc[mode] = 0;
                fl_inc[mode] = 0;
                loads   = 7'b1111111;
                flushes = 3'b000;
                if (!rst) begin
                    exp_ctrl[mode] = {1'b1, 1'b0, 5'b11111, 3'b000, 2'd0, 2'd0};
                end else begin
                    if (!released) begin
                        loads = '0;
                        st_inc[mode] = 1;
                    end else if (redirect) begin
                        flushes = 3'b111;
                        fl_inc[mode] = 1;
                    end else if (hz) begin
                        loads[6:5] = 2'b00;
                        flushes = 3'b010;
                        st_inc[mode] = 1;
                    end
                    exp_ctrl[mode] = {!m_i_have, mem_op && !m_d_have, loads[6:2], flushes,
                                      fwd_of(mode, idex_rs1), fwd_of(mode, idex_rs2)};
                end
            end

            exp_if  = (rst && m_i_have) ? m_i_data : icache_rdata;
            exp_mem = (rst && m_d_have) ? m_d_data : dcache_rdata;

            got_ctrl[1] = {f_icache_req, f_dcache_req, f_pc_load, f_ifid_load, f_idex_load, f_exmem_load,
                           f_memwb_load, f_ifid_flush, f_idex_flush, f_exmem_flush, f_fwd_a, f_fwd_b};
            got_ctrl[0] = {n_icache_req, n_dcache_req, n_pc_load, n_ifid_load, n_idex_load, n_exmem_load,
                           n_memwb_load, n_ifid_flush, n_idex_flush, n_exmem_flush, n_fwd_a, n_fwd_b};

            check($sformatf("c%0d fwd ctrl", cyc), 64'(got_ctrl[1]), 64'(exp_ctrl[1]));
            check($sformatf("c%0d fwd if_rdata", cyc), 64'(f_if_rdata), 64'(exp_if));
            check($sformatf("c%0d fwd mem_rdata", cyc), 64'(f_mem_rdata), 64'(exp_mem));
            check($sformatf("c%0d fwd stall_cycles", cyc), 64'(f_stall_cycles), 64'(m_stall[1]));
            check($sformatf("c%0d fwd flush_count", cyc), 64'(f_flush_count), 64'(m_flush[1]));
            check($sformatf("c%0d nofwd ctrl", cyc), 64'(got_ctrl[0]), 64'(exp_ctrl[0]));
            check($sformatf("c%0d nofwd if_rdata", cyc), 64'(n_if_rdata), 64'(exp_if));
            check($sformatf("c%0d nofwd mem_rdata", cyc), 64'(n_mem_rdata), 64'(exp_mem));
            check($sformatf("c%0d nofwd stall_cycles", cyc), 64'(n_stall_cycles), 64'(m_stall[0]));
            check($sformatf("c%0d nofwd flush_count", cyc), 64'(n_flush_count), 64'(m_flush[0]));

            if (!rst) begin
                m_i_have = 0; m_d_have = 0; m_i_data = '0; m_d_data = '0;
                m_stall = '{default: '0};
                m_flush = '{default: '0};
            end else begin
                if (released) begin
                    m_i_have = 0;
                    m_d_have = 0;
                end else begin
                    if (icache_resp && !m_i_have) begin
                        m_i_have = 1;
                        m_i_data = icache_rdata;
                    end
                    if (mem_op && dcache_resp && !m_d_have) begin
                        m_d_have = 1;
                        m_d_data = dcache_rdata;
                    end
                end
                for (int mode = 0; mode < 2; mode++) begin
                    if (st_inc[mode]) m_stall[mode] = m_stall[mode] + 1;
                    if (fl_inc[mode]) m_flush[mode] = m_flush[mode] + 1;
                end
            end
            prev_stall = rst && !released;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall, flush and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Replaces the current always-load, never-stall scheme: it drives every pipeline-register load and flush, gates cache requests, and holds cache read data across multi-cycle misses.
- Selects the EX operand forwarding sources, or stalls on RAW hazards in no-forward mode.
- Sits beside the datapath and observes decoded register fields plus both cache responses.

Parameters:
- XLEN, 32, data and instruction word width.
- REG_W, 5, register-index width.
- ENABLE_FWD, 1, 1 = forwarding plus load-use stall; 0 = stall until the producer leaves WB.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- icache_resp  in  1  one-cycle instruction-cache response.
- icache_rdata  in  XLEN  instruction-cache data.
- dcache_resp  in  1  one-cycle data-cache response.
- dcache_rdata  in  XLEN  data-cache data.
- mem_op  in  1  the MEM stage holds a load or store.
- id_rs1, id_rs2  in  REG_W  source registers in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1 / rs2.
- idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd  in  REG_W  stage register fields.
- idex_wr, exmem_wr, memwb_wr  in  1  that stage writes the regfile.
- idex_is_load  in  1  EX holds a load.
- redirect  in  1  taken branch, jal or jalr resolved in MEM.
- icache_req  out  1  instruction-cache read enable.
- dcache_req  out  1  qualifies the dcache read/write from MEM.
- if_rdata  out  XLEN  instruction word delivered to IF/ID.
- mem_rdata  out  XLEN  load data delivered to MEM/WB.
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1  pipeline-register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous bubble insert.
- fwd_a, fwd_b  out  2  EX operand source: 0 = regfile, 1 = EX/MEM ALU result, 2 = WB regfilemux.
- stall_cycles, flush_count  out  CNT_W  performance counters.

Behaviour:
- Cache protocol: a request is held stable until resp; resp is a single-cycle pulse.
- Reset (rst==0 at the clock edge):
  - FSM returns to RUN.
  - Holding registers and counters clear to 0.
  - All outputs reset combinationally to their RUN values for an empty pipeline: icache_req=1, loads=1, flushes=0, fwd=0.
- Memory FSM states:
  - RUN: no cycle-level stall.
  - WAIT: icache and/or dcache outstanding.
  - D_DONE: dcache has responded, icache is still pending.
  - I_DONE: icache has responded, dcache is still pending.
- FSM transitions:
  - RUN→WAIT when icache_resp==0, or when mem_op&&dcache_resp==0.
  - WAIT→RUN when every outstanding response arrives in the same cycle.
  - WAIT→D_DONE on dcache_resp alone: latch dcache_rdata; dcache_req=0.
  - WAIT→I_DONE on icache_resp alone: latch icache_rdata; icache_req=0.
  - D_DONE→RUN on icache_resp.
  - I_DONE→RUN on dcache_resp.
  - A pending request is never re-issued after its response.
- Memory stall = FSM not advancing to RUN this cycle. During a memory stall every *_load=0 and every flush is suppressed.
- Data selection:
  - if_rdata = latched word in I_DONE, icache_rdata otherwise.
  - mem_rdata = latched word in D_DONE, dcache_rdata otherwise.
- Hazard stall, evaluated only when there is no memory stall:
  - ENABLE_FWD=1: load-use stall if idex_is_load && idex_rd!=0 && a used ID source equals idex_rd.
  - ENABLE_FWD=0: stall if a used ID source (nonzero) matches the rd of any writing stage among idex, exmem and memwb.
  - Response: pc_load=ifid_load=0 and idex_flush=1; exmem and memwb keep advancing.
- Forwarding (ENABLE_FWD=1):
  - fwd_a=1 if exmem_wr && exmem_rd!=0 && exmem_rd==idex_rs1.
  - Otherwise fwd_a=2 if the same test holds against memwb.
  - Otherwise fwd_a=0.
  - fwd_b follows the same rules against idex_rs2.
  - With ENABLE_FWD=0, fwd_a and fwd_b are always 0.
- Redirect, when there is no memory stall:
  - ifid_flush=idex_flush=exmem_flush=1 on the same edge that pc loads the target.
  - Redirect takes priority over the hazard stall.
  - A redirect during a memory stall waits until the stall ends.
- Counters:
  - stall_cycles increments on any memory or hazard stall cycle.
  - flush_count increments once per redirect taken.
  - Both counters wrap modulo 2^CNT_W.
- Reset mid-miss:
  - FSM goes to RUN immediately.
  - A late resp arriving while in RUN with no request outstanding is ignored.

Decomposition:
- ctrl_types package gains:
  - mem_state_t enum {RUN, WAIT, D_DONE, I_DONE}.
  - fwd_sel_t enum {FWD_RF=0, FWD_EXMEM=1, FWD_WB=2}.
- One natural sub-module: fwd_unit, combinational forwarding and hazard compare, instantiated once.

Test Plan:
- Load-use dependency: lw x5,0(x1) then add x6,x5,x2 with immediate cache hits → exactly one bubble; fwd_a=2 on the add; stall_cycles=1.
- Back-to-back ALU ops: addi x3,x0,7 then sub x4,x3,x3 → fwd_a=fwd_b=1; no stall.
- Split cache responses: icache_resp delayed 5 cycles, dcache_resp in cycle 2 with data 0xDEADBEEF → FSM WAIT→D_DONE→RUN; mem_rdata=0xDEADBEEF at release; dcache_req=0 from cycle 3; no loads asserted for 5 cycles.
- Redirect during an icache miss: beq taken while icache_resp is delayed 3 cycles → flushes deferred until the resp; then 3 flushes in one cycle; flush_count=1.
- ENABLE_FWD=0 build: dependent add directly after an addi → 3 stall cycles; fwd_a=fwd_b=0 throughout.
- Reset mid-WAIT: rst=0 for one cycle, then a stray icache_resp arrives → state is RUN and the stray resp produces no latch or counter change.
